// File: rtl/tri_pkg.sv
// Shared rasterizer package: grid geometry and the collector state encoding.
//   COORD_W : coordinate width (grid is 2**COORD_W square)
//   GRID_N  : grid edge length in pixels
//   state_t : collector FSM states
package tri_pkg;
  localparam int COORD_W = 3;
  localparam int GRID_N  = 1 << COORD_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    SKIP    = 2'd3
  } state_t;
endpackage

// File: rtl/tri_pixel_collector_if.sv
// Row drain bus between the pixel collector and the display/compare stage.
//   row_valid : a bitmap row is being presented
//   row_ready : consumer accepts the presented row this cycle
//   row_data  : bitmap row, bit k = pixel at x=k
//   row_idx   : index of the row being presented
// master = collector side, slave = consumer side.
interface tri_pixel_collector_if;
  import tri_pkg::*;

  logic                row_valid;
  logic                row_ready;
  logic [GRID_N-1:0]   row_data;
  logic [COORD_W-1:0]  row_idx;

  modport master (output row_valid, output row_data, output row_idx, input row_ready);
  modport slave  (input row_valid, input row_data, input row_idx, output row_ready);
endinterface

// File: rtl/tri_bitmap64.sv
// 8x8 occupancy bitmap. Bit index is {y, x}, so row y occupies bits
// [y*8 +: 8] with bit k of the row being column x=k.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clear every bit (wins over set_en)
//   set_en     : set the bit at (set_x, set_y)
//   was_set    : that bit's value before this cycle's set
//   rd_row     : row to read
//   row_data   : combinational read of row rd_row
module tri_bitmap64
  import tri_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                set_en,
  input  logic [COORD_W-1:0]  set_x,
  input  logic [COORD_W-1:0]  set_y,
  output logic                was_set,
  input  logic [COORD_W-1:0]  rd_row,
  output logic [GRID_N-1:0]   row_data
);

  logic [GRID_N*GRID_N-1:0] bits;

  assign was_set  = bits[{set_y, set_x}];
  assign row_data = bits[{rd_row, {COORD_W{1'b0}}} +: GRID_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits <= '0;
    end else if (clr) begin
      bits <= '0;
    end else if (set_en) begin
      bits[{set_y, set_x}] <= 1'b1;
    end
  end

endmodule

// File: rtl/tri_pixel_collector.sv
// Triangle pixel collector: captures the rasterizer pixel stream framed by
// busy_in into an 8x8 bitmap, counts distinct pixels, then drains the bitmap
// one row per handshake. Flags duplicate pixels and frames lost to overrun.
//   clk, reset   : clock, asynchronous active-high reset
//   busy_in      : rasterizer busy (rise = frame start, fall = frame end)
//   po, xi, yi   : pixel valid and its coordinates
//   row          : row drain bus (master side)
//   pix_count    : distinct pixels of the last/current frame
//   frame_done   : one-cycle pulse after the last row is accepted
//   dup_err      : sticky, a pixel was written twice within a frame
//   ovr_err      : sticky, a frame started while draining
//   err_clr      : synchronous clear of dup_err/ovr_err
module tri_pixel_collector #(
  parameter int COORD_W = tri_pkg::COORD_W,
  parameter int CNT_W   = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   busy_in,
  input  logic                   po,
  input  logic [COORD_W-1:0]     xi,
  input  logic [COORD_W-1:0]     yi,
  tri_pixel_collector_if.master  row,
  output logic [CNT_W-1:0]       pix_count,
  output logic                   frame_done,
  output logic                   dup_err,
  output logic                   ovr_err,
  input  logic                   err_clr
);
  import tri_pkg::*;

  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(GRID_N * GRID_N);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(GRID_N - 1);

  state_t               state, state_nx;
  logic                 busy_d, rise, fall;
  logic                 skip_pend;
  logic [COORD_W-1:0]   row_idx;
  logic                 bm_clr, bm_set, was_set;
  logic [GRID_N-1:0]    bm_row;
  logic                 accept, last_accept, drain_rise;

  assign rise = busy_in & ~busy_d;
  assign fall = ~busy_in & busy_d;

  assign row.row_valid = (state == DRAIN);
  assign row.row_idx   = row_idx;
  assign row.row_data  = (state == DRAIN) ? bm_row : '0;

  assign accept      = row.row_valid & row.row_ready;
  assign last_accept = accept & (row_idx == LAST_ROW);
  // A new frame arriving while the previous one is still being drained.
  assign drain_rise  = (state == DRAIN) & rise;

  tri_bitmap64 u_bitmap (
    .clk      (clk),
    .reset    (reset),
    .clr      (bm_clr),
    .set_en   (bm_set),
    .set_x    (xi),
    .set_y    (yi),
    .was_set  (was_set),
    .rd_row   (row_idx),
    .row_data (bm_row)
  );

  always_comb begin
    state_nx = state;
    bm_clr   = 1'b0;
    bm_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx = COLLECT;
          bm_clr   = 1'b1;
        end
      end
      COLLECT: begin
        // The pixel presented with the falling busy edge still belongs to the frame.
        bm_set = po;
        if (fall) state_nx = DRAIN;
      end
      DRAIN: begin
        // An overrun frame that is still running must be let through unseen;
        // one that already ended during the drain needs no skipping.
        if (last_accept) state_nx = (skip_pend | rise) ? SKIP : IDLE;
      end
      SKIP: begin
        if (fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy_d     <= 1'b0;
      skip_pend  <= 1'b0;
      row_idx    <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
      dup_err    <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      busy_d     <= busy_in;
      frame_done <= last_accept;

      if (drain_rise)  skip_pend <= 1'b1;
      else if (fall)   skip_pend <= 1'b0;

      if ((state == COLLECT) && fall) row_idx <= '0;
      else if (accept)                row_idx <= row_idx + 1'b1;

      if (bm_clr)
        pix_count <= '0;
      else if (bm_set && !was_set && (pix_count != CNT_MAX))
        pix_count <= pix_count + 1'b1;

      // A new error in the same cycle as err_clr keeps the flag set.
      if (bm_set && was_set) dup_err <= 1'b1;
      else if (err_clr)      dup_err <= 1'b0;

      if (drain_rise)        ovr_err <= 1'b1;
      else if (err_clr)      ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Self-checking bench for tri_pixel_collector: directed scenarios plus
// randomized frames compared against a set-of-pixels reference model.
module tb_tri_pixel_collector;

  typedef struct {
    int x;
    int y;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy_in = 1'b0;
  logic       po = 1'b0;
  logic [2:0] xi = '0;
  logic [2:0] yi = '0;
  logic       err_clr = 1'b0;
  logic [6:0] pix_count;
  logic       frame_done, dup_err, ovr_err;

  int checks = 0;
  int errors = 0;

  pix_t     frame_q[$];
  bit [7:0] m_rows[8];
  int       m_cnt;
  bit       m_dup;

  tri_pixel_collector_if rowbus();

  tri_pixel_collector #(.COORD_W(3), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .busy_in    (busy_in),
    .po         (po),
    .xi         (xi),
    .yi         (yi),
    .row        (rowbus),
    .pix_count  (pix_count),
    .frame_done (frame_done),
    .dup_err    (dup_err),
    .ovr_err    (ovr_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // Reference: the frame is the set of pixels sent; rows are bit-or of x per y.
  function automatic void build_model();
    for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
    m_cnt = 0;
    m_dup = 1'b0;
    foreach (frame_q[i]) begin
      if (m_rows[frame_q[i].y][frame_q[i].x]) m_dup = 1'b1;
      else begin
        m_rows[frame_q[i].y][frame_q[i].x] = 1'b1;
        m_cnt++;
      end
    end
    if (m_cnt > 64) m_cnt = 64;
  endfunction

  task automatic send_frame(input int clr_at);
    @(negedge clk); busy_in = 1'b1; po = 1'b0; err_clr = 1'b0;
    if (frame_q.size() == 0) begin
      @(negedge clk); busy_in = 1'b0;
    end else begin
      foreach (frame_q[i]) begin
        @(negedge clk);
        po = 1'b1; xi = 3'(frame_q[i].x); yi = 3'(frame_q[i].y);
        err_clr = (i == clr_at);
        if (i == frame_q.size() - 1) busy_in = 1'b0;
      end
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  // Drains all 8 rows against m_rows; optional stall and in-drain frame start.
  task automatic drain_rows(input string nm, input int stall_row, input int stall_len, input int rise_row);
    int hold;
    for (int r = 0; r < 8; r++) begin
      hold = (r == stall_row) ? stall_len : 0;
      for (int h = 0; h <= hold; h++) begin
        @(negedge clk);
        if (r == 0 && h == 0) begin err_clr = 1'b0; if (rise_row < 0) po = 1'b0; end
        if (r == rise_row && h == 0) begin
          busy_in = 1'b1; po = 1'b1; xi = 3'($urandom_range(0, 7)); yi = 3'd6;
        end
        checks++; if (rowbus.row_valid !== 1'b1) begin errors++; $display("FAIL %s row_valid r%0d h%0d: got %b want 1", nm, r, h, rowbus.row_valid); end
        checks++; if (rowbus.row_idx !== 3'(r)) begin errors++; $display("FAIL %s row_idx h%0d: got %0d want %0d", nm, h, rowbus.row_idx, r); end
        checks++; if (rowbus.row_data !== m_rows[r]) begin errors++; $display("FAIL %s row_data r%0d h%0d: got %h want %h", nm, r, h, rowbus.row_data, m_rows[r]); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL %s early frame_done r%0d: got %b want 0", nm, r, frame_done); end
        rowbus.row_ready = (h == hold);
      end
    end
    @(negedge clk); rowbus.row_ready = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL %s frame_done: got %b want 1", nm, frame_done); end
    checks++; if (rowbus.row_valid !== 1'b0) begin errors++; $display("FAIL %s row_valid after drain: got %b want 0", nm, rowbus.row_valid); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL %s frame_done pulse width: got %b want 0", nm, frame_done); end
  endtask

  task automatic check_frame_stats(input string nm);
    checks++; if (pix_count !== 7'(m_cnt)) begin errors++; $display("FAIL %s pix_count: got %0d want %0d", nm, pix_count, m_cnt); end
    checks++; if (dup_err !== m_dup) begin errors++; $display("FAIL %s dup_err: got %b want %b", nm, dup_err, m_dup); end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++; if (pix_count !== 7'd0) begin errors++; $display("FAIL %s pix_count: got %0d want 0", nm, pix_count); end
    checks++; if (rowbus.row_valid !== 1'b0) begin errors++; $display("FAIL %s row_valid: got %b want 0", nm, rowbus.row_valid); end
    checks++; if (rowbus.row_data !== 8'h00) begin errors++; $display("FAIL %s row_data: got %h want 00", nm, rowbus.row_data); end
    checks++; if (rowbus.row_idx !== 3'd0) begin errors++; $display("FAIL %s row_idx: got %0d want 0", nm, rowbus.row_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL %s frame_done: got %b want 0", nm, frame_done); end
    checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL %s dup_err: got %b want 0", nm, dup_err); end
    checks++; if (ovr_err !== 1'b0) begin errors++; $display("FAIL %s ovr_err: got %b want 0", nm, ovr_err); end
  endtask

  task automatic test_reset();
    rowbus.row_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");
  endtask

  task automatic test_basic();
    frame_q = '{'{0, 0}, '{1, 0}, '{0, 1}};
    build_model();
    send_frame(-1);
    drain_rows("basic", -1, 0, -1);
    check_frame_stats("basic");
    checks++; if (pix_count !== 7'd3) begin errors++; $display("FAIL basic count3: got %0d want 3", pix_count); end
  endtask

  task automatic test_dup();
    frame_q = '{'{5, 5}, '{5, 5}};
    build_model();
    send_frame(1);
    drain_rows("dup", -1, 0, -1);
    check_frame_stats("dup");
    pulse_clr();
    @(negedge clk);
    checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup clear: got %b want 0", dup_err); end
  endtask

  task automatic test_stall();
    frame_q = '{'{3, 2}, '{7, 2}, '{0, 7}, '{4, 0}};
    build_model();
    send_frame(-1);
    drain_rows("stall", 2, 4, -1);
    check_frame_stats("stall");
  endtask

  task automatic test_full();
    int v[64];
    int j, t;
    for (int i = 0; i < 64; i++) v[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i); t = v[i]; v[i] = v[j]; v[j] = t;
    end
    frame_q.delete();
    for (int i = 0; i < 64; i++) frame_q.push_back('{v[i] % 8, v[i] / 8});
    build_model();
    send_frame(-1);
    drain_rows("full", -1, 0, -1);
    check_frame_stats("full");
    checks++; if (pix_count !== 7'd64) begin errors++; $display("FAIL full count64: got %0d want 64", pix_count); end
  endtask

  task automatic test_overrun();
    int a_cnt;
    pulse_clr();
    frame_q = '{'{1, 0}, '{6, 1}, '{2, 1}};
    build_model();
    a_cnt = m_cnt;
    send_frame(-1);
    drain_rows("ovr_drain", -1, 0, 2);
    @(negedge clk);
    checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr flag: got %b want 1", ovr_err); end
    xi = 3'd3; yi = 3'd4;
    repeat (3) @(negedge clk);
    busy_in = 1'b0; xi = 3'd5;
    @(negedge clk); po = 1'b0;
    @(negedge clk);
    checks++; if (pix_count !== 7'(a_cnt)) begin errors++; $display("FAIL ovr skipped count: got %0d want %0d", pix_count, a_cnt); end
    checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL ovr skipped dup: got %b want 0", dup_err); end
    checks++; if (rowbus.row_valid !== 1'b0) begin errors++; $display("FAIL ovr skipped drain: got %b want 0", rowbus.row_valid); end
    frame_q = '{'{0, 3}, '{7, 3}, '{4, 4}};
    build_model();
    send_frame(-1);
    drain_rows("ovr_next", -1, 0, -1);
    check_frame_stats("ovr_next");
    pulse_clr();
    @(negedge clk);
    checks++; if (ovr_err !== 1'b0) begin errors++; $display("FAIL ovr clear: got %b want 0", ovr_err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); busy_in = 1'b1; po = 1'b0;
    @(negedge clk); po = 1'b1; xi = 3'd2; yi = 3'd3;
    @(negedge clk);
    @(negedge clk); xi = 3'd7; yi = 3'd7;
    checks++; if (pix_count !== 7'd1) begin errors++; $display("FAIL rst_mid pre count: got %0d want 1", pix_count); end
    checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL rst_mid pre dup: got %b want 1", dup_err); end
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_mid");
    busy_in = 1'b0; po = 1'b0;
    @(negedge clk); reset = 1'b0;
    frame_q = '{'{1, 1}, '{6, 6}};
    build_model();
    send_frame(-1);
    drain_rows("rst_next", -1, 0, -1);
    check_frame_stats("rst_next");
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 8; f++) begin
      pulse_clr();
      frame_q.delete();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) frame_q.push_back('{$urandom_range(0, 7), $urandom_range(0, 7)});
      build_model();
      send_frame(-1);
      drain_rows($sformatf("rand%0d", f), $urandom_range(0, 7), $urandom_range(0, 3), -1);
      check_frame_stats($sformatf("rand%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_stall();
    test_full();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
